// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types, flag encodings and defaults for the memory access
//            controller (state enum, load/store width codes, legality check).
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // flagLoad encodings
  localparam logic [2:0] LD_WORD   = 3'b000;
  localparam logic [2:0] LD_HALF_S = 3'b001;
  localparam logic [2:0] LD_HALF_U = 3'b010;
  localparam logic [2:0] LD_BYTE_S = 3'b011;
  localparam logic [2:0] LD_BYTE_U = 3'b100;

  // flagStore encodings
  localparam logic [1:0] SD_WORD = 2'b00;
  localparam logic [1:0] SD_HALF = 2'b01;
  localparam logic [1:0] SD_BYTE = 2'b10;

  // Legal width code and natural alignment for a single-strobe access.
  function automatic logic access_ok(input logic       is_read,
                                     input logic [2:0] fl,
                                     input logic [1:0] fs,
                                     input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (is_read) begin
      case (fl)
        LD_WORD:              ok = (a == 2'b00);
        LD_HALF_S, LD_HALF_U: ok = ~a[0];
        LD_BYTE_S, LD_BYTE_U: ok = 1'b1;
        default:              ok = 1'b0;
      endcase
    end else begin
      case (fs)
        SD_WORD: ok = (a == 2'b00);
        SD_HALF: ok = ~a[0];
        SD_BYTE: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_if
// Purpose  : Memory request/response bus between the access controller
//            (master) and the data memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if #(
  parameter int AW = 32
);
  logic          memReq;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [31:0]   memWdata;
  logic [3:0]    memBe;
  logic [31:0]   memRdata;
  logic          memAck;

  modport master (
    output memReq, memWe, memAddr, memWdata, memBe,
    input  memRdata, memAck
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata, memBe,
    output memRdata, memAck
  );
endinterface
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_fmt
// Purpose  : Little-endian lane steering: store byte enables / replicated
//            write data, and load byte/half selection with sign/zero extend.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_fmt
  import mem_ctrl_pkg::*;
(
  input  logic        is_read_i,
  input  logic [1:0]  st_addr_i,
  input  logic [1:0]  st_flag_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_addr_i,
  input  logic [2:0]  ld_flag_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Store side: reads always enable all lanes; writes replicate the datum.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = 32'h0;
    if (!is_read_i) begin
      case (st_flag_i)
        SD_HALF: begin
          be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{st_data_i[15:0]}};
        end
        SD_BYTE: begin
          be_o    = 4'b0001 << st_addr_i;
          wdata_o = {4{st_data_i[7:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = st_data_i;
        end
      endcase
    end
  end

  // Load side: pick the addressed half/byte and extend to 32 bits.
  always_comb begin
    w_half = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_addr_i)
      2'd0:    w_byte = ld_rdata_i[7:0];
      2'd1:    w_byte = ld_rdata_i[15:8];
      2'd2:    w_byte = ld_rdata_i[23:16];
      default: w_byte = ld_rdata_i[31:24];
    endcase
    case (ld_flag_i)
      LD_HALF_S: ld_data_o = {{16{w_half[15]}}, w_half};
      LD_HALF_U: ld_data_o = {16'h0, w_half};
      LD_BYTE_S: ld_data_o = {{24{w_byte[7]}}, w_byte};
      LD_BYTE_U: ld_data_o = {24'h0, w_byte};
      default:   ld_data_o = ld_rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : EX/MEM data-memory access controller. Validates the access,
//            issues one request, waits for ack (bounded by TIMEOUT), formats
//            load data and stalls the pipeline while the access is pending.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       dataRt,
  input  logic [2:0]        flagLoad,
  input  logic [1:0]        flagStore,
  mem_access_ctrl_if.master bus,
  output logic [31:0]       loadData,
  output logic              stall,
  output logic              accErr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          memReq_q;
  logic          memWe_q;
  logic [AW-1:0] memAddr_q;
  logic [31:0]   memWdata_q;
  logic [3:0]    memBe_q;
  logic [31:0]   loadData_q;
  logic          accErr_q;
  logic [1:0]    ldAddr_q;
  logic [2:0]    ldFlag_q;

  logic          w_any;
  logic          w_ok;
  logic          w_err;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   load_d;

  assign w_any = memRead | memWrite;
  assign w_ok  = (memRead ^ memWrite) &&
                 access_ok(memRead, flagLoad, flagStore, addr[1:0]);
  assign w_err = w_any && !w_ok;

  // Store lanes come from the live inputs (captured on REQ entry); load
  // formatting uses the latched address/flags against the returning word.
  mem_lane_fmt u_lane (
    .is_read_i  (memRead),
    .st_addr_i  (addr[1:0]),
    .st_flag_i  (flagStore),
    .st_data_i  (dataRt),
    .be_o       (be_d),
    .wdata_o    (wdata_d),
    .ld_addr_i  (ldAddr_q),
    .ld_flag_i  (ldFlag_q),
    .ld_rdata_i (bus.memRdata),
    .ld_data_o  (load_d)
  );

  // Pipeline freeze: a valid access in IDLE holds upstream until DONE.
  assign stall = ((state_q == S_IDLE) && w_ok) || (state_q == S_REQ);

  // Access FSM with registered bus, error pulse and load result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= 32'h0;
      memBe_q    <= 4'h0;
      loadData_q <= 32'h0;
      accErr_q   <= 1'b0;
      ldAddr_q   <= 2'b00;
      ldFlag_q   <= 3'b000;
    end else begin
      accErr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_ok) begin
            state_q    <= S_REQ;
            cnt_q      <= '0;
            memReq_q   <= 1'b1;
            memWe_q    <= memWrite;
            memAddr_q  <= {addr[AW-1:2], 2'b00};
            memBe_q    <= be_d;
            memWdata_q <= wdata_d;
            ldAddr_q   <= addr[1:0];
            ldFlag_q   <= flagLoad;
          end else if (w_err) begin
            accErr_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.memAck || (cnt_q == CW'(TIMEOUT - 1))) begin
            state_q    <= S_DONE;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= 32'h0;
            memBe_q    <= 4'h0;
            if (bus.memAck) begin
              if (!memWe_q) begin
                loadData_q <= load_d;
              end
            end else begin
              accErr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.memReq   = memReq_q;
  assign bus.memWe    = memWe_q;
  assign bus.memAddr  = memAddr_q;
  assign bus.memWdata = memWdata_q;
  assign bus.memBe    = memBe_q;
  assign loadData     = loadData_q;
  assign accErr       = accErr_q;

endmodule
`default_nettype wire
